// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d, done_q, done_d;

    logic               neg_a, neg_b, ge;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [2*WIDTH-1:0] prod;

    assign neg_a   = ~op[0] & SrcA[WIDTH-1];
    assign neg_b   = ~op[0] & SrcB[WIDTH-1];
    assign abs_a   = neg_a ? -SrcA : SrcA;
    assign abs_b   = neg_b ? -SrcB : SrcB;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    // Divide keeps the dividend/quotient in the low half of acc and shifts it into the remainder.
    assign rem_sh  = {rem_q, acc_q[WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, m_q};
    assign prod    = neg_res_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                div_d     = op[1];
                neg_res_d = neg_a ^ neg_b;
                neg_rem_d = neg_a;
                dz_d      = op[1] & ~|SrcB;
                m_d       = op[1] ? abs_b : abs_a;
                acc_d     = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = RUN;
            end else begin
                hi_d = mthi ? SrcA : hi_q;
                lo_d = mtlo ? SrcA : lo_q;
            end
        end else if (state_q == RUN) begin
            acc_d   = div_q ? {acc_q[2*WIDTH-2:0], ge} : {mul_sum, acc_q[WIDTH-1:1]};
            rem_d   = !div_q ? rem_q : (ge ? rem_sh[WIDTH-1:0] - m_q : rem_sh[WIDTH-1:0]);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIXUP : RUN;
        end else if (state_q == FIXUP) begin
            // A zero divisor leaves |SrcA| in the remainder, so re-signing it restores raw SrcA.
            hi_d    = div_q ? (neg_rem_q ? -rem_q : rem_q) : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? (dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]))
                            : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int failed = 0;

    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[1] && b == 32'd0) return {a, 32'hFFFFFFFF};
        case (o)
            2'd0:    return 64'(sa * sb);
            2'd1:    return {32'b0, a} * {32'b0, b};
            2'd2:    return {32'(sa % sb), 32'(sa / sb)};
            default: return {a % b, a / b};
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: a result becomes visible WIDTH+1 edges after an accepted start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
            end else if (start) begin
                m_pend <= ref_res(op, SrcA, SrcB);
                m_cnt  <= 33;
            end else begin
                if (mthi) m_hi <= SrcA;
                if (mtlo) m_lo <= SrcA;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, m_cnt != 0);
            chk("done", done, m_done);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit lit, input logic [31:0] eh, input logic [31:0] el, input int poke);
        int cyc = 0;
        int bcnt = 0;
        start = 1'b1;
        op    = o;
        SrcA  = a;
        SrcB  = b;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) bcnt++;
            if (cyc == 1) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
                op    = 2'($urandom);
                SrcA  = $urandom;
                SrcB  = $urandom;
            end
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                mthi  = 1'b1;
                SrcA  = 32'h12345678;
            end
            if (poke != 0 && cyc == poke + 1) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
        end
        chk("latency", cyc, 34);
        chk("busy_cycles", bcnt, 33);
        if (lit) begin
            chk("lit_hi", hi, eh);
            chk("lit_lo", lo, el);
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        SrcA  = '0;
        SrcB  = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
        do_op(2'd0, 32'hFFFFFFFD, 32'd5,        1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        do_op(2'd0, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0);
        do_op(2'd2, 32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        do_op(2'd3, 32'd7,        32'd2,        1, 32'h00000001, 32'h00000003, 0);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);
        do_op(2'd3, 32'd100,      32'd0,        1, 32'h00000064, 32'hFFFFFFFF, 0);
        do_op(2'd2, 32'hFFFFFF9C, 32'd0,        1, 32'hFFFFFF9C, 32'hFFFFFFFF, 0);
        do_op(2'd1, 32'd6,        32'd7,        1, 32'h00000000, 32'h0000002A, 10);
        mthi = 1'b1;
        mtlo = 1'b1;
        SrcA = 32'hCAFEF00D;
        @(negedge clk);
        chk("mt_hi", hi, 32'hCAFEF00D);
        chk("mt_lo", lo, 32'hCAFEF00D);
        chk("mt_done", done, 0);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        start = 1'b1;
        op    = 2'd0;
        SrcA  = 32'd3;
        SrcB  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(2'd0, 32'hFFFFFFF9, 32'd6, 1, 32'hFFFFFFFF, 32'hFFFFFFD6, 0);
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                mthi = 1'($urandom);
                mtlo = 1'($urandom);
                SrcA = $urandom;
                @(negedge clk);
            end
            mthi = 1'($urandom);
            mtlo = 1'($urandom);
            do_op(ro, ra, rb, 0, 32'd0, 32'd0, 0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
